// File: rtl/addsub8_sequencer.sv
// addsub8_sequencer: 8-bit add/subtract built from one 4-bit ripple-carry
// slice used twice (low nibble, then high nibble) with a registered carry.
// Valid/ready handshake on both the operand and the result side.
// Optional macro ADDSUB8_SEQ_OVF_EN enables the signed-overflow flag;
// without it ovf is tied to 0 and the overflow logic is absent.
module addsub8_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  input  logic       mode,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] s,
  output logic       cout,
  output logic       ovf
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t     state, state_nxt;
  logic [7:0] a_q, b_q;
  logic       cin_q, mode_q;
  logic       c4;
  logic [3:0] s_lo;
  logic [7:0] s_q;
  logic       cout_q;

  logic [3:0] sl_a, sl_b, sl_sum;
  logic       sl_cin, sl_cout;
  logic       rc;

  // State register; reset returns to IDLE from any state
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs, decoded from state only
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = LO;
      end
      LO:   state_nxt = HI;
      HI:   state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture at accept; later input changes are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      cin_q  <= 1'b0;
      mode_q <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_q    <= a;
      b_q    <= b;
      cin_q  <= cin;
      mode_q <= mode;
    end
  end

  // Slice operand select: high nibble in HI, low nibble otherwise; B inverted for subtract
  always_comb begin
    sl_a   = (state == HI) ? a_q[7:4] : a_q[3:0];
    sl_b   = ((state == HI) ? b_q[7:4] : b_q[3:0]) ^ {4{mode_q}};
    sl_cin = (state == HI) ? c4 : (mode_q | cin_q);
  end

  // The single 4-bit ripple-carry slice
  always_comb begin
    sl_sum = '0;
    rc     = sl_cin;
    for (int unsigned i = 0; i < 4; i++) begin
      sl_sum[i] = sl_a[i] ^ sl_b[i] ^ rc;
      rc        = (sl_a[i] & sl_b[i]) | (rc & (sl_a[i] ^ sl_b[i]));
    end
    sl_cout = rc;
  end

  // Low nibble is staged in s_lo so the visible result only changes in HI
  always_ff @(posedge clk) begin
    if (rst) begin
      c4     <= 1'b0;
      s_lo   <= '0;
      s_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        LO: begin
          s_lo <= sl_sum;
          c4   <= sl_cout;
        end
        HI: begin
          s_q    <= {sl_sum, s_lo};
          cout_q <= sl_cout;
        end
        default: ;
      endcase
    end
  end

  assign s    = s_q;
  assign cout = cout_q;

`ifdef ADDSUB8_SEQ_OVF_EN
  logic ovf_q;

  // Signed overflow: carry into bit 7 differs from carry out of bit 7
  always_ff @(posedge clk) begin
    if (rst)              ovf_q <= 1'b0;
    else if (state == HI) ovf_q <= a_q[7] ^ sl_b[3] ^ sl_sum[3] ^ sl_cout;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_addsub8_sequencer.sv
// Self-checking bench for addsub8_sequencer: directed vectors, random
// operations, backpressure, back-to-back throughput and mid-op reset,
// all checked against an arithmetic reference model.
module tb_addsub8_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b;
  logic       cin, mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] s;
  logic       cout;
  logic       ovf;

  int n_checks = 0;
  int n_fail   = 0;

  addsub8_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Reference: returns {cout, ovf, s[7:0]} from plain integer arithmetic
  function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                       input logic mcin, input logic mmode);
    int unsigned r;
    int sa, sb, sr;
    logic o;
    sa = (ma >= 128) ? int'(ma) - 256 : int'(ma);
    sb = (mb >= 128) ? int'(mb) - 256 : int'(mb);
    if (!mmode) begin
      r  = ma + mb + mcin;
      sr = sa + sb + int'(mcin);
    end else begin
      r  = ma + (255 - mb) + 1;
      sr = sa - sb;
    end
`ifdef ADDSUB8_SEQ_OVF_EN
    o = (sr > 127) || (sr < -128);
`else
    o = 1'b0;
`endif
    return {(r >= 256) ? 1'b1 : 1'b0, o, r[7:0]};
  endfunction

  // Issue one operation, scramble inputs after accept, wait for the result,
  // then release it after ready_delay cycles. lat counts edges after accept.
  task automatic do_op(input logic [7:0] oa, input logic [7:0] ob, input logic ocin,
                       input logic omode, input int ready_delay,
                       output logic [9:0] res, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    in_valid = 1'b1; a = oa; b = ob; cin = ocin; mode = omode;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); mode = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    res = {cout, ovf, s};
    repeat (ready_delay) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, out_valid, cout, ovf, s} !== 12'h800) begin
      n_fail++;
      $display("FAIL reset: got in_ready=%b out_valid=%b cout=%b ovf=%b s=%h, want 1 0 0 0 00",
               in_ready, out_valid, cout, ovf, s);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [7:0] ta [4] = '{8'h37, 8'hFF, 8'h05, 8'h7F};
    logic [7:0] tb [4] = '{8'h29, 8'h00, 8'h07, 8'h01};
    logic       tc [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic       tm [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [9:0] res, exp;
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tb[i], tc[i], tm[i], 0, res, lat);
      exp = model(ta[i], tb[i], tc[i], tm[i]);
      n_checks++;
      if (res !== exp) begin
        n_fail++;
        $display("FAIL directed[%0d] result: got cout=%b ovf=%b s=%h, want cout=%b ovf=%b s=%h",
                 i, res[9], res[8], res[7:0], exp[9], exp[8], exp[7:0]);
      end
      n_checks++;
      if (lat !== 2) begin
        n_fail++;
        $display("FAIL directed[%0d] latency: got %0d, want 2", i, lat);
      end
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL directed[%0d] return_idle: got in_ready=%b out_valid=%b, want 1 0",
                 i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] ra, rb;
    logic rc, rm;
    logic [9:0] res, exp;
    int lat;
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rm = 1'($urandom);
      do_op(ra, rb, rc, rm, int'($urandom_range(0, 3)), res, lat);
      exp = model(ra, rb, rc, rm);
      n_checks++;
      if (res !== exp || lat !== 2) begin
        n_fail++;
        $display("FAIL random[%0d] a=%h b=%h cin=%b mode=%b: got {cout,ovf,s}=%h lat=%0d, want %h lat=2",
                 i, ra, rb, rc, rm, res, lat, exp);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [9:0] held, exp;
    int w;
    exp = model(8'hC3, 8'h5A, 1'b0, 1'b1);
    in_valid = 1'b1; a = 8'hC3; b = 8'h5A; cin = 1'b0; mode = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 20) begin
      @(posedge clk); #1; w++;
    end
    held = {cout, ovf, s};
    n_checks++;
    if (held !== exp) begin
      n_fail++;
      $display("FAIL backpressure result: got %h, want %h", held, exp);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 1 || i == 2);
      a = 8'($urandom); b = 8'($urandom);
      @(posedge clk); #1;
      n_checks++;
      if ({cout, ovf, s} !== held || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL backpressure hold[%0d]: got {cout,ovf,s}=%h in_ready=%b out_valid=%b, want %h 0 1",
                 i, {cout, ovf, s}, in_ready, out_valid, held);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure release: got in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure no_queue: got in_ready=%b, want 1", in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] expq[$];
    logic [9:0] exp;
    int cyc, accepted, done, last_acc;
    cyc = 0; accepted = 0; done = 0; last_acc = 0;
    out_ready = 1'b1;
    while (done < 8 && cyc < 200) begin
      in_valid = (accepted < 8);
      if (in_valid && in_ready) begin
        expq.push_back(model(a, b, cin, mode));
        if (accepted > 0) begin
          n_checks++;
          if (cyc - last_acc !== 4) begin
            n_fail++;
            $display("FAIL back_to_back interval: got %0d cycles, want 4", cyc - last_acc);
          end
        end
        last_acc = cyc;
        accepted++;
      end
      if (out_valid) begin
        exp = (expq.size() > 0) ? expq.pop_front() : 10'h3FF;
        n_checks++;
        if ({cout, ovf, s} !== exp) begin
          n_fail++;
          $display("FAIL back_to_back result[%0d]: got %h, want %h", done, {cout, ovf, s}, exp);
        end
        done++;
      end
      @(posedge clk); #1;
      cyc++;
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); mode = 1'($urandom);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (done !== 8) begin
      n_fail++;
      $display("FAIL back_to_back timeout: got %0d results, want 8", done);
    end
  endtask

  task automatic test_reset_midop();
    logic [9:0] res;
    int lat;
    bit seen;
    do_op(8'hA5, 8'h3C, 1'b1, 1'b0, 0, res, lat);
    in_valid = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0; mode = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, cout, ovf, s} !== 12'h800) begin
      n_fail++;
      $display("FAIL reset_midop state: got in_ready=%b out_valid=%b cout=%b ovf=%b s=%h, want 1 0 0 0 00",
               in_ready, out_valid, cout, ovf, s);
    end
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    out_ready = 1'b0;
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midop discard: got out_valid seen=%b, want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
